// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, FSM encoding and rounding helper for cordic_polar_post
package cordic_pkg;

  localparam logic [15:0] K_INV_Q16      = 16'd39797;
  localparam logic [15:0] ANG_SCALE_CDEG = 16'd36000;
  localparam logic [31:0] ROUND_HALF     = 32'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_R = 2'd1,
    MUL_T = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Round-half-up of a Q16 product back to an integer; cannot overflow for our operands.
  function automatic logic [15:0] round_q16(input logic [31:0] prod);
    return 16'((prod + ROUND_HALF) >> 16);
  endfunction

endpackage

// File: rtl/serial_mult16.sv
// rtl/serial_mult16.sv - unsigned 16x16->32 LSB-first shift-add multiplier, 16 steps after start
module serial_mult16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o
);

  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [31:0] acc_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [16:0] sum;
  logic [31:0] acc_d;

  // Add the current partial product into the upper half, then shift the whole accumulator right.
  always_comb begin
    sum   = {1'b0, acc_q[31:16]} + {1'b0, (b_q[0] ? a_q : 16'd0)};
    acc_d = 32'({sum, acc_q[15:0]} >> 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        busy_q <= 1'b0;
      end
    end
  end

  // done flags the cycle whose edge retires the last partial product; product_o is valid with it.
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == 4'd15);
  assign product_o = acc_d;

endmodule

// File: rtl/cordic_polar_post.sv
// rtl/cordic_polar_post.sv - CORDIC gain correction and binary-angle to centidegree conversion
module cordic_polar_post
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter logic [15:0] K_INV     = K_INV_Q16,
  parameter logic [15:0] ANG_SCALE = ANG_SCALE_CDEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] theta_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mag_out,
  output logic [WIDTH-1:0] deg_out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, theta_q, mag_q;
  logic [WIDTH-1:0] mag_out_q, deg_out_q;
  logic             out_valid_q, in_ready_q;
  logic             accept;

  logic             mul_start, mul_busy, mul_done;
  logic [15:0]      mul_a, mul_b;
  logic [31:0]      mul_product;

  assign accept = (state_q == IDLE) && in_valid && in_ready_q;

  serial_mult16 u_mult (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (mul_a),
    .b_i       (mul_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The angle product is launched on the first MUL_T cycle, after mag has been captured.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_a     = r_q;
    mul_b     = K_INV;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mul_start = 1'b1;
          mul_a     = r_in;
          state_d   = MUL_R;
        end
      end
      MUL_R: begin
        if (mul_done) begin
          state_d = MUL_T;
        end
      end
      MUL_T: begin
        mul_a = theta_q;
        mul_b = ANG_SCALE;
        if (!mul_busy) begin
          mul_start = 1'b1;
        end else if (mul_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q         <= '0;
      theta_q     <= '0;
      mag_q       <= '0;
      mag_out_q   <= '0;
      deg_out_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      in_ready_q <= (state_d == IDLE);
      if (accept) begin
        r_q     <= r_in;
        theta_q <= theta_in;
      end
      if ((state_q == MUL_R) && mul_done) begin
        mag_q <= round_q16(mul_product);
      end
      if ((state_q == MUL_T) && mul_done) begin
        mag_out_q   <= mag_q;
        deg_out_q   <= round_q16(mul_product);
        out_valid_q <= 1'b1;
      end
      if ((state_q == DONE) && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mag_out   = mag_out_q;
  assign deg_out   = deg_out_q;

endmodule

// File: doc/cordic_polar_post.md
Name: cordic_polar_post

Overview:
- Downstream stage of rect_to_polar. It consumes the raw CORDIC magnitude `r` (gain-inflated by K≈1.64676) and the binary-angle `theta`.
- It produces a gain-corrected magnitude and an angle in centidegrees.
- Shares one serial 16x16 shift-add multiplier across both corrections, so area stays small.
- Connects to rect_to_polar outputs via a valid/ready handshake. Feeds display/UART formatting logic.

Parameters:
- WIDTH, 16, data width of r, theta and both outputs. Only 16 is verified.
- K_INV, 39797, 1/K in unsigned Q0.16 (0.607253·65536).
- ANG_SCALE, 36000, centidegrees per full turn. theta full scale 65536 = 360°.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset. Asserts immediately; release is synchronous to clk upstream.
- in_valid  in  1  r_in/theta_in valid
- in_ready  out  1  block can accept a sample
- r_in  in  WIDTH  unsigned raw CORDIC magnitude
- theta_in  in  WIDTH  unsigned binary angle (0..65535 = 0..<360°)
- out_valid  out  1  results valid
- out_ready  in  1  downstream accepts results
- mag_out  out  WIDTH  round((r_in·K_INV)/2^16)
- deg_out  out  WIDTH  round((theta_in·ANG_SCALE)/2^16), range 0..35999 (65535 maps to 35999, never 36000)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; in_ready=0 while rst=0.
  - out_valid=0; mag_out=0; deg_out=0; internal registers cleared.
  - The first clk edge after release drives in_ready=1.
- FSM states: IDLE, MUL_R, MUL_T, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready at an edge, latch r_in and theta_in, start the multiplier with (r, K_INV), and go to MUL_R. in_ready=0 in every other state.
  - MUL_R: 16 cycles, one partial product per cycle (LSB-first, add-and-shift into a 32-bit accumulator). On done, mag = (acc+0x8000)>>16, start the multiplier with (theta, ANG_SCALE), go to MUL_T.
  - MUL_T: 16 cycles. On done, deg = (acc+0x8000)>>16, load mag_out/deg_out, set out_valid=1, go to DONE.
  - DONE: hold mag_out, deg_out and out_valid stable while out_ready=0. On out_valid&out_ready at an edge: out_valid=0, go to IDLE.
- Latency: out_valid rises exactly 33 clk edges after the accepting edge. With out_ready tied high, throughput is 1 sample per 35 cycles.
- Arithmetic:
  - Unsigned, 32-bit products.
  - Rounding is round-half-up via +0x8000 before truncation.
  - No overflow is possible: 65535·39797>>16 = 39796, and max deg is 35999.
- Boundary conditions:
  - in_valid asserted outside IDLE is ignored; upstream must hold data until in_ready.
  - Simultaneous out_ready and a new in_valid in DONE: only the output handshake completes. The input is accepted at the earliest one cycle later, in IDLE.
  - r_in=0 gives mag_out=0. theta_in=0 gives deg_out=0.
  - Reset mid-multiply or in DONE aborts immediately. The pending result is discarded and out_valid is forced to 0.

Decomposition:
- Shared package/include `cordic_pkg` holds:
  - K_INV_Q16=39797
  - ANG_SCALE_CDEG=36000
  - ROUND_HALF=32'h8000
  - the FSM state encoding (2-bit: IDLE=0, MUL_R=1, MUL_T=2, DONE=3)
- One sub-module: `serial_mult16`. It is an unsigned 16x16→32 multiplier with start/busy/done, taking 16 cycles after start, and is reset by the same rst.

Test Plan:
- Reset check: rst=0 mid-stream → out_valid=0, mag_out=0, deg_out=0, in_ready=0 while rst=0. After release, in_ready=1 on the next edge.
- 45° case: r_in=38156, theta_in=8192, out_ready=1 → 33 edges later out_valid=1, mag_out=23170, deg_out=4500, then back to IDLE.
- Cardinal angles:
  - r_in=53960, theta_in=0 → mag_out=32767, deg_out=0.
  - theta_in=32768 → deg_out=18000.
  - theta_in=16384 → deg_out=9000.
- Wrap edge: theta_in=65535, r_in=65535 → deg_out=35999, mag_out=39796.
- Backpressure: out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0, and a new in_valid is not accepted. Raising out_ready completes the transfer, and the next sample is accepted one cycle later.
- Reset abort: assert rst=0 during MUL_T → out_valid stays 0 and no result is emitted. A post-reset sample with r_in=0, theta_in=0 yields mag_out=0, deg_out=0.
